// File: rtl/bla_sub_seq_if.sv
// Handshake/bus bundle for the sequential borrow-lookahead subtractor.
// master: drives start/a/b; slave: returns busy/done/diff/borrow/overflow.
interface bla_sub_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, overflow
    );
endinterface

// File: rtl/bla_sub_seq.sv
// Multi-cycle subtractor diff = a - b, one SLICE-bit borrow-lookahead slice
// per clock (LSB first), borrow rippled between slices through a register.
// Ports: clk, rst_n (async, active low), bus (bla_sub_seq_if.slave):
//   start/a/b in; busy/done/diff/borrow/overflow out.
// Optional: define BLA_SUB_SAT_EN to commit a signed-saturated diff on overflow.
module bla_sub_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    bla_sub_seq_if.slave bus
);
    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             last;

    logic [IW-1:0]    idx_q;
    logic             bin_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] work_d;

    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             ovf_q;

    int               off;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [SLICE-1:0] sa;
    logic [SLICE-1:0] sb;
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   br;
    logic [SLICE-1:0] sd;

    logic             ovf_raw;
    logic [WIDTH-1:0] diff_commit;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end
            end
            RUN: begin
                if (idx_q == IW'(N - 1)) begin
                    state_d = IDLE;
                    last    = 1'b1;
                end
            end
        endcase
    end

    // ---------------- slice datapath ----------------
    assign off  = int'(idx_q) * SLICE;
    assign a_sh = a_q >> off;
    assign b_sh = b_q >> off;
    assign sa   = a_sh[SLICE-1:0];
    assign sb   = b_sh[SLICE-1:0];

    // Borrow into bit i+1 is a flat sum of products over generate/propagate
    // terms, so the slice has no internal ripple chain.
    always_comb begin
        logic term;
        logic pp;
        term  = 1'b0;
        pp    = 1'b0;
        g     = ~sa & sb;
        p     = ~(sa ^ sb);
        br    = '0;
        br[0] = bin_q;
        for (int i = 0; i < SLICE; i++) begin
            term = g[i];
            pp   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (pp & g[j]);
                pp   = pp & p[j];
            end
            br[i+1] = term | (pp & bin_q);
        end
        sd = sa ^ sb ^ br[SLICE-1:0];
    end

    // Working register with the current slice merged in; on the last slice
    // this is the complete raw difference.
    always_comb begin
        logic [WIDTH-1:0] mask;
        mask   = WIDTH'({SLICE{1'b1}}) << off;
        work_d = (work_q & ~mask) | (WIDTH'(sd) << off);
    end

    assign ovf_raw = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                     (work_d[WIDTH-1] != a_q[WIDTH-1]);

`ifdef BLA_SUB_SAT_EN
    // Overflow can only go away from a's sign, so saturate toward it.
    always_comb begin
        diff_commit = work_d;
        if (ovf_raw) begin
            diff_commit = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign diff_commit = work_d;
`endif

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            idx_q    <= '0;
            bin_q    <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= last;
            if (accept) begin
                a_q    <= bus.a;
                b_q    <= bus.b;
                work_q <= '0;
                idx_q  <= '0;
                bin_q  <= 1'b0;
            end else if (state_q == RUN) begin
                work_q <= work_d;
                bin_q  <= br[SLICE];
                if (last) begin
                    idx_q    <= '0;
                    diff_q   <= diff_commit;
                    borrow_q <= br[SLICE];
                    ovf_q    <= ovf_raw;
                end else begin
                    idx_q <= idx_q + IW'(1);
                end
            end
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = done_q;
    assign bus.diff     = diff_q;
    assign bus.borrow   = borrow_q;
    assign bus.overflow = ovf_q;

endmodule
